// File: rtl/fetch_unit.sv
// Fetch stage: owns the program counter, drives the program memory address,
// latches the returned word into the instruction register and hands it to the
// decoder together with the PC it came from. Handles stall, PC-relative
// branch, absolute jump and halt, and counts every word accepted as valid.
module fetch_unit #(
  parameter int Psize = 6,
  parameter int Isize = 24,
  parameter int Csize = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [Psize-1:0] branch_offset,
  input  logic             jump_en,
  input  logic [Psize-1:0] jump_addr,
  input  logic             halt,
  input  logic [Isize-1:0] I,
  output logic [Psize-1:0] address,
  output logic [Isize-1:0] instr,
  output logic [Psize-1:0] ir_pc,
  output logic             instr_valid,
  output logic             halted,
  output logic [Csize-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [Psize-1:0] pc, pc_nxt;
  logic [Isize-1:0] instr_nxt;
  logic [Psize-1:0] ir_pc_nxt;
  logic             valid_nxt;
  logic [Csize-1:0] count_nxt;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [Csize-1:0] sat_inc(input logic [Csize-1:0] c);
    return (&c) ? c : c + Csize'(1);
  endfunction

  // Branch target is relative to the fetched instruction's own address and
  // wraps modulo the program memory depth.
  function automatic logic [Psize-1:0] branch_target(
    input logic [Psize-1:0]        base,
    input logic signed [Psize-1:0] off
  );
    logic signed [Psize-1:0] sum;
    sum = $signed(base) + off;
    return $unsigned(sum);
  endfunction

  assign address = pc;
  assign halted  = (state == S_HALT);

  // Next-state and next-register values; everything holds unless a case below moves it.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    ir_pc_nxt = ir_pc;
    valid_nxt = instr_valid;
    count_nxt = fetch_count;
    case (state)
      S_HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        // Redirect requests only count for a valid IR; in FLUSH the IR is
        // always invalid, so the bubble cycle can only fetch or stall.
        if (halt && instr_valid) begin
          state_nxt = S_HALT;
          valid_nxt = 1'b0;
        end else if (stall) begin
          state_nxt = state;
        end else if (jump_en && instr_valid) begin
          pc_nxt    = jump_addr;
          valid_nxt = 1'b0;
          state_nxt = S_FLUSH;
        end else if (branch_en && instr_valid) begin
          pc_nxt    = branch_target(ir_pc, $signed(branch_offset));
          valid_nxt = 1'b0;
          state_nxt = S_FLUSH;
        end else begin
          instr_nxt = I;
          ir_pc_nxt = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + Psize'(1);
          count_nxt = sat_inc(fetch_count);
          state_nxt = S_RUN;
        end
      end
    endcase
  end

  // State and fetch registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      pc          <= '0;
      instr       <= '0;
      ir_pc       <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      ir_pc       <= ir_pc_nxt;
      instr_valid <= valid_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural model predicts the registered outputs
// for every clock, the prediction is queued when inputs are driven and popped
// when the DUT has clocked. Directed scenarios add fixed-value checks.
module tb_fetch_unit;

  localparam int Psize = 6;
  localparam int Isize = 24;
  localparam int Csize = 5;

  logic             clk = 1'b0;
  logic             reset, stall, branch_en, jump_en, halt;
  logic [Psize-1:0] branch_offset, jump_addr;
  logic [Isize-1:0] I;
  logic [Psize-1:0] address, ir_pc;
  logic [Isize-1:0] instr;
  logic             instr_valid, halted;
  logic [Csize-1:0] fetch_count;

  logic [Isize-1:0] mem [2**Psize];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [Psize-1:0] addr;
    logic [Isize-1:0] ins;
    logic [Psize-1:0] irpc;
    logic             vld;
    logic             hlt;
    logic [Csize-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Model state
  logic [Psize-1:0] m_pc;
  logic [Isize-1:0] m_ir;
  logic [Psize-1:0] m_irpc;
  logic             m_vld, m_hlt;
  logic [Csize-1:0] m_cnt;

  fetch_unit #(.Psize(Psize), .Isize(Isize), .Csize(Csize)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_addr(jump_addr),
    .halt(halt), .I(I), .address(address), .instr(instr), .ir_pc(ir_pc),
    .instr_valid(instr_valid), .halted(halted), .fetch_count(fetch_count)
  );

  assign I = mem[address];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    logic signed [Psize-1:0] off;
    off = $signed(branch_offset);
    if (reset) begin
      m_pc = '0; m_ir = '0; m_irpc = '0; m_vld = 1'b0; m_hlt = 1'b0; m_cnt = '0;
    end else if (m_hlt) begin
      m_vld = 1'b0;
    end else if (halt && m_vld) begin
      m_hlt = 1'b1; m_vld = 1'b0;
    end else if (stall) begin
      m_vld = m_vld;
    end else if (jump_en && m_vld) begin
      m_pc = jump_addr; m_vld = 1'b0;
    end else if (branch_en && m_vld) begin
      m_pc = Psize'(m_irpc + off); m_vld = 1'b0;
    end else begin
      m_ir = mem[m_pc]; m_irpc = m_pc; m_vld = 1'b1; m_pc = m_pc + 6'd1;
      if (m_cnt != {Csize{1'b1}}) m_cnt = m_cnt + 5'd1;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.addr = m_pc; e.ins = m_ir; e.irpc = m_irpc;
    e.vld = m_vld; e.hlt = m_hlt; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_address", 32'(address), 32'(e.addr));
      check("sb_instr", 32'(instr), 32'(e.ins));
      check("sb_ir_pc", 32'(ir_pc), 32'(e.irpc));
      check("sb_valid", 32'(instr_valid), 32'(e.vld));
      check("sb_halted", 32'(halted), 32'(e.hlt));
      check("sb_count", 32'(fetch_count), 32'(e.cnt));
    end
  endtask

  task automatic run_until_irpc(input logic [Psize-1:0] target, input int budget);
    int k;
    k = 0;
    while (!(instr_valid && ir_pc == target) && k < budget) begin
      step();
      k++;
    end
    check("reach_ir_pc", 32'(ir_pc), 32'(target));
  endtask

  initial begin
    logic [Csize-1:0] c0;
    m_pc = '0; m_ir = '0; m_irpc = '0; m_vld = 1'b0; m_hlt = 1'b0; m_cnt = '0;
    for (int i = 0; i < 2**Psize; i++) mem[i] = {18'($urandom), 6'(i)};
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0; halt = 1'b0;
    branch_offset = '0; jump_addr = '0;

    // 1: reset and sequential start
    repeat (3) step();
    check("rst_address", 32'(address), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    reset = 1'b0;
    step();
    check("t1_address1", 32'(address), 32'd1);
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", 32'(instr), 32'(mem[0]));
    check("t1_ir_pc", 32'(ir_pc), 32'd0);
    step(); step();
    check("t1_address3", 32'(address), 32'd3);

    // 2: branch back by 3 from ir_pc 5
    run_until_irpc(6'd5, 10);
    c0 = fetch_count;
    branch_en = 1'b1; branch_offset = 6'b111101;
    step();
    check("t2_address", 32'(address), 32'd2);
    check("t2_bubble", 32'(instr_valid), 32'd0);
    branch_en = 1'b0;
    step();
    check("t2_instr", 32'(instr), 32'(mem[2]));
    check("t2_ir_pc", 32'(ir_pc), 32'd2);
    check("t2_count", 32'(fetch_count), 32'(c0 + 5'd1));

    // 4: stall holds everything, branch taken only once released
    c0 = fetch_count;
    stall = 1'b1; branch_en = 1'b1; branch_offset = 6'd4;
    repeat (4) begin
      step();
      check("t4_address", 32'(address), 32'd3);
      check("t4_instr", 32'(instr), 32'(mem[2]));
      check("t4_count", 32'(fetch_count), 32'(c0));
    end
    stall = 1'b0;
    step();
    check("t4_taken", 32'(address), 32'd6);
    check("t4_bubble", 32'(instr_valid), 32'd0);
    branch_en = 1'b0;

    // 5: halt at ir_pc 7
    reset = 1'b1; step(); reset = 1'b0;
    run_until_irpc(6'd7, 12);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_valid", 32'(instr_valid), 32'd0);
    stall = 1'b1; jump_en = 1'b1; jump_addr = 6'd40;
    repeat (10) begin
      step();
      check("t5_pc_frozen", 32'(address), 32'd8);
    end
    stall = 1'b0; jump_en = 1'b0; reset = 1'b1;
    step();
    check("t5_rst_address", 32'(address), 32'd0);
    check("t5_rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;

    // 3: jump from 62 to 1, wrap at 63, counter saturation
    run_until_irpc(6'd62, 80);
    jump_en = 1'b1; jump_addr = 6'd1;
    step();
    jump_en = 1'b0;
    check("t3_bubble", 32'(instr_valid), 32'd0);
    step();
    check("t3_ir_pc", 32'(ir_pc), 32'd1);
    run_until_irpc(6'd63, 80);
    check("t3_wrap_address", 32'(address), 32'd0);
    step();
    check("t3_wrap_ir_pc", 32'(ir_pc), 32'd0);
    check("t3_count_sat", 32'(fetch_count), 32'd31);

    // 6: reset during the flush bubble
    jump_en = 1'b1; jump_addr = 6'd20;
    step();
    jump_en = 1'b0; reset = 1'b1;
    step();
    check("t6_address", 32'(address), 32'd0);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_instr", 32'(instr), 32'd0);
    check("t6_count", 32'(fetch_count), 32'd0);
    reset = 1'b0;
    step();
    check("t6_ir_pc", 32'(ir_pc), 32'd0);
    check("t6_address1", 32'(address), 32'd1);
    check("t6_instr0", 32'(instr), 32'(mem[0]));

    // Random mix of stalls and redirects, checked by the model
    for (int n = 0; n < 300; n++) begin
      stall         = ($urandom_range(0, 4) == 0);
      branch_en     = ($urandom_range(0, 6) == 0);
      jump_en       = ($urandom_range(0, 9) == 0);
      branch_offset = 6'($urandom);
      jump_addr     = 6'($urandom);
      step();
    end
    stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
